// File: rtl/addsub_pkg.sv
// addsub_pkg: shared flag type, op encoding and slice sizing helper
// for the pipelined adder/subtractor.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic ovf;
        logic carry;
        logic zero;
        logic neg;
    } flags_t;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: one combinational carry slice with carry in/out and a
// zero indication for its own sum bits.
module addsub_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         zero
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign zero        = (sum == '0);

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: STAGES-deep pipelined add/sub with valid/ready and flags.
// Define ADDSUB_SATURATE_EN to clamp overflowing results.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_ovf,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int SW   = slice_w(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;
    localparam int NR   = (STAGES > 1) ? STAGES - 1 : 1;

    logic                          advance;
    logic [WIDTH-1:0]              b_eff;
    logic [STAGES-1:0]             vld_q;
    logic [NR-1:0][WIDTH-1:0]      a_q, b_q, r_q;
    logic [NR-1:0]                 c_q, z_q;
    logic [STAGES-1:0][WIDTH-1:0]  src_a, src_b, src_r, nx_r;
    logic [STAGES-1:0]             src_c, src_z, nx_c, nx_z, sl_zero;
    logic [STAGES-1:0][SW-1:0]     sl_sum;
    logic [WIDTH-1:0]              res_q, fin_r;
    flags_t                        flg_q, fin_f;
    logic                          a_msb, b_msb, r_msb, ovf;

    assign advance = !vld_q[LAST] || out_ready;
    assign b_eff   = (in_sub == OP_ADD) ? in_b : ~in_b;

    // Slice k works on operands skewed k cycles; lower result bits ride along.
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        if (k == 0) begin : g_head
            assign src_a[k] = in_a;
            assign src_b[k] = b_eff;
            assign src_r[k] = '0;
            assign src_c[k] = (in_sub == OP_SUB);
            assign src_z[k] = 1'b1;
        end else begin : g_tail
            assign src_a[k] = a_q[k-1];
            assign src_b[k] = b_q[k-1];
            assign src_r[k] = r_q[k-1];
            assign src_c[k] = c_q[k-1];
            assign src_z[k] = z_q[k-1];
        end

        addsub_slice #(.W(SW)) u_slice (
            .a    (src_a[k][k*SW +: SW]),
            .b    (src_b[k][k*SW +: SW]),
            .cin  (src_c[k]),
            .sum  (sl_sum[k]),
            .cout (nx_c[k]),
            .zero (sl_zero[k])
        );

        assign nx_r[k] = src_r[k] | (WIDTH'(sl_sum[k]) << (k * SW));
        assign nx_z[k] = src_z[k] & sl_zero[k];
    end

    assign a_msb = src_a[LAST][WIDTH-1];
    assign b_msb = src_b[LAST][WIDTH-1];
    assign r_msb = nx_r[LAST][WIDTH-1];
    assign ovf   = (a_msb == b_msb) && (r_msb != a_msb);

`ifdef ADDSUB_SATURATE_EN
    assign fin_r = !ovf ? nx_r[LAST] :
                   a_msb ? {1'b1, {(WIDTH-1){1'b0}}} :
                           {1'b0, {(WIDTH-1){1'b1}}};
    assign fin_f.zero = nx_z[LAST] & ~ovf;
`else
    assign fin_r = nx_r[LAST];
    assign fin_f.zero = nx_z[LAST];
`endif
    assign fin_f.ovf   = ovf;
    assign fin_f.carry = nx_c[LAST];
    assign fin_f.neg   = fin_r[WIDTH-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            c_q   <= '0;
            z_q   <= '0;
            res_q <= '0;
            flg_q <= '0;
        end else if (advance) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 0; k < LAST; k++) begin
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                r_q[k] <= nx_r[k];
                c_q[k] <= nx_c[k];
                z_q[k] <= nx_z[k];
            end
            res_q <= fin_r;
            flg_q <= fin_f;
        end
    end

    assign in_ready   = advance;
    assign out_valid  = vld_q[LAST];
    assign out_result = res_q;
    assign out_ovf    = flg_q.ovf;
    assign out_carry  = flg_q.carry;
    assign out_zero   = flg_q.zero;
    assign out_neg    = flg_q.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: vector table plus scoreboard bench for addsub_pipe
// (WIDTH=32, STAGES=2); honours ADDSUB_SATURATE_EN in its expectations.
module tb_addsub_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [31:0] r;
        logic        ovf;
        logic        carry;
        logic        zero;
        logic        neg;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        exp_t        e;
    } vec_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid, in_ready, in_sub;
    logic [WIDTH-1:0] in_a, in_b, out_result;
    logic             out_valid, out_ovf, out_carry, out_zero, out_neg;
    logic             out_ready = 1'b1;

    int   checks   = 0;
    int   failures = 0;
    int   rdy_mode = 0;
    int   rdy_cnt  = 0;
    exp_t sbq[$];
    exp_t held, act;
    logic stalled = 1'b0;
    vec_t vecs[8];

    always #5 clock = ~clock;

    addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_neg    (out_neg)
    );

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference: signed range test for overflow, unsigned compare for borrow.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub);
        exp_t        e;
        longint      sa, sbv, s;
        logic [32:0] u;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (sub) begin
            s       = sa - sbv;
            e.r     = a - b;
            e.carry = (a >= b);
        end else begin
            s       = sa + sbv;
            u       = {1'b0, a} + {1'b0, b};
            e.r     = u[31:0];
            e.carry = u[32];
        end
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef ADDSUB_SATURATE_EN
        if (e.ovf) e.r = a[31] ? 32'h8000_0000 : 32'h7fff_ffff;
`endif
        e.zero = (e.r == 32'd0);
        e.neg  = e.r[31];
        return e;
    endfunction

    always @(negedge clock) begin
        #1;
        if (rdy_mode == 0) begin
            out_ready = 1'b1;
        end else begin
            out_ready = (rdy_cnt % 3 == 0);
            rdy_cnt++;
        end
    end

    // Output monitor: scoreboard pop, handshake rule and stall stability.
    always @(negedge clock) begin
        #3;
        act = {out_result, out_ovf, out_carry, out_zero, out_neg};
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) chk("stall_hold", act, held);
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_result: got %h expected none", act);
                end else begin
                    chk("result", act, sbq.pop_front());
                end
            end
            stalled = out_valid && !out_ready;
            held    = act;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input exp_t e);
        bit ok;
        ok = 0;
        #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        #1;
        repeat (50) begin
            if (in_ready) begin
                sbq.push_back(e);
                ok = 1;
                break;
            end
            @(negedge clock);
            #2;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(negedge clock);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clock);
            #4;
            n++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [31:0] ra, rb;
        logic        rs;

        vecs[0] = '{32'h7fff_ffff, 32'h0000_0001, 1'b0, {32'h8000_0000, 4'b1001}};
        vecs[1] = '{32'hffff_ffff, 32'h8000_0000, 1'b1, {32'h7fff_ffff, 4'b0100}};
        vecs[2] = '{32'h0000_0000, 32'h8000_0000, 1'b1, {32'h8000_0000, 4'b1001}};
        vecs[3] = '{32'h0000_0005, 32'h0000_0005, 1'b1, {32'h0000_0000, 4'b0110}};
        vecs[4] = '{32'hffff_ffff, 32'h0000_0001, 1'b0, {32'h0000_0000, 4'b0110}};
        vecs[5] = '{32'h0000_0003, 32'h0000_0005, 1'b1, {32'hffff_fffe, 4'b0001}};
        vecs[6] = '{32'h0000_ffff, 32'h0000_0001, 1'b0, {32'h0001_0000, 4'b0000}};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, {32'h0000_0000, 4'b1110}};
`ifdef ADDSUB_SATURATE_EN
        vecs[0].e = {32'h7fff_ffff, 4'b1000};
        vecs[2].e = {32'h7fff_ffff, 4'b1000};
        vecs[7].e = {32'h8000_0000, 4'b1101};
`endif

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_sub   = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", out_result, 32'd0);
        chk("rst_flags", {out_ovf, out_carry, out_zero, out_neg}, 4'd0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].e);
        end
        in_valid = 1'b0;
        drain();

        // Single beat: out_valid rises STAGES-1 edges after acceptance.
        send(32'h1234_5678, 32'h1111_1111, 1'b0,
             {32'h2345_6789, 4'b0000});
        in_valid = 1'b0;
        #4;
        for (int i = 0; i < STAGES - 1; i++) begin
            chk("lat_wait", out_valid, 1'b0);
            @(negedge clock);
            #4;
        end
        chk("lat_hit", out_valid, 1'b1);
        drain();

        rdy_cnt  = 0;
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs));
        end
        in_valid = 1'b0;
        drain();
        rdy_mode = 0;
        @(negedge clock);

        send(32'h0000_0010, 32'h0000_0001, 1'b1, model(32'h10, 32'h1, 1'b1));
        send(32'h0000_0020, 32'h0000_0002, 1'b0, model(32'h20, 32'h2, 1'b0));
        in_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_flight_valid", out_valid, 1'b0);
        chk("rst_flight_ready", in_ready, 1'b1);
        chk("rst_flight_result", out_result, 32'd0);
        sbq.delete();
        repeat (2) @(negedge clock);
        #1;
        reset_n = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clock);
            #4;
            if (out_valid) cnt++;
        end
        chk("no_result_after_reset", cnt, 0);
        send(32'h0000_0007, 32'h0000_0002, 1'b1, {32'h0000_0005, 4'b0100});
        in_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
